mem_port_arbiter: RTL and testbench

- Shares one single-port, variable-latency memory between instruction fetch (F stage) and load/store (M stage) of the pipelined core.
- Sits between the core and the memory, replacing the separate instruction and data ports.
- Per pipeline step, it serialises the data access first (older instruction), then the fetch. It holds the whole pipeline with `MemStall` until both accesses complete.
- A watchdog flags a memory that never answers.

---
 rtl/riscv_mem_pkg.sv | 15 +
 rtl/mem_wdog.sv | 35 +++
 rtl/mem_port_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the memory port arbiter.
package riscv_mem_pkg;

  // Arbiter states: ARB issues the first access of a step, FETCH issues the
  // instruction fetch that follows a data access, DONE releases the pipeline.
  typedef enum logic [1:0] {
    ARB   = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } arb_state_t;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam logic [2:0]  MEMCTL_WORD = 3'b010;

endpackage

// File: rtl/mem_wdog.sv
// Watchdog for a memory that never answers: saturating wait counter and a
// sticky error flag that only reset clears. Requests are never aborted.
module mem_wdog #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic ready,
  output logic bus_err
);

  localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

  logic [7:0] wait_cnt;

  // Count waiting cycles, clear on completion, and latch the error one cycle
  // after the counter reaches the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= 8'd0;
      bus_err  <= 1'b0;
    end else begin
      if (req && ready) begin
        wait_cnt <= 8'd0;
      end else if (req && (wait_cnt != LIMIT)) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (wait_cnt == LIMIT) begin
        bus_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port, variable-latency memory between instruction fetch
// and load/store. Each pipeline step runs the data access first (it belongs
// to the older instruction), then the fetch, and holds the pipeline with
// MemStall until both have completed.
//
// Memory handshake: a request is presented while mem_req=1 with all request
// fields held stable; it completes on the rising edge where mem_ready=1.
// mem_ready while mem_req=0 has no effect.
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCF,
  output logic [31:0] InstrF,
  input  logic        MemReqM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [2:0]  MemControlM,
  output logic [31:0] ReadDataM,
  output logic        MemStall,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_ctrl,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  arb_state_t state, state_next;
  logic       data_phase;   // current request is the load/store
  logic       fetch_phase;  // current request is the instruction fetch

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ARB;
    else       state <= state_next;
  end

  // Next state and request fields; all memory outputs are forced low in reset.
  always_comb begin
    state_next  = state;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = 32'd0;
    mem_wdata   = 32'd0;
    mem_ctrl    = 3'd0;
    data_phase  = 1'b0;
    fetch_phase = 1'b0;
    case (state)
      ARB: begin
        mem_req = 1'b1;
        if (MemReqM) begin
          data_phase = 1'b1;
          mem_we     = MemWriteM;
          mem_addr   = ALUResultM;
          mem_wdata  = WriteDataM;
          mem_ctrl   = MemControlM;
          if (mem_ready) state_next = FETCH;
        end else begin
          fetch_phase = 1'b1;
          mem_addr    = PCF;
          mem_ctrl    = MEMCTL_WORD;
          if (mem_ready) state_next = DONE;
        end
      end
      FETCH: begin
        mem_req     = 1'b1;
        fetch_phase = 1'b1;
        mem_addr    = PCF;
        mem_ctrl    = MEMCTL_WORD;
        if (mem_ready) state_next = DONE;
      end
      DONE: begin
        state_next = ARB;
      end
      default: begin
        state_next = ARB;
      end
    endcase
    if (reset) begin
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = 32'd0;
      mem_wdata   = 32'd0;
      mem_ctrl    = 3'd0;
      data_phase  = 1'b0;
      fetch_phase = 1'b0;
    end
  end

  assign MemStall = reset || (state != DONE);

  // Capture load data and fetched instructions on completion; stores leave
  // ReadDataM untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      InstrF    <= NOP_INSTR;
      ReadDataM <= 32'd0;
    end else if (mem_req && mem_ready) begin
      if (data_phase && !MemWriteM) ReadDataM <= mem_rdata;
      if (fetch_phase)              InstrF    <= mem_rdata;
    end
  end

  mem_wdog #(
    .WAIT_LIMIT(WAIT_LIMIT)
  ) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .req     (mem_req),
    .ready   (mem_ready),
    .bus_err (bus_err)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a memory responder with scripted wait
// states, a scoreboard of expected memory requests and step results, and
// per-step latency / hold / watchdog checks.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic [31:0] PCF;
  logic [31:0] InstrF;
  logic        MemReqM;
  logic        MemWriteM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [2:0]  MemControlM;
  logic [31:0] ReadDataM;
  logic        MemStall;
  logic        bus_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_ctrl;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  mem_port_arbiter #(.WAIT_LIMIT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .PCF         (PCF),
    .InstrF      (InstrF),
    .MemReqM     (MemReqM),
    .MemWriteM   (MemWriteM),
    .ALUResultM  (ALUResultM),
    .WriteDataM  (WriteDataM),
    .MemControlM (MemControlM),
    .ReadDataM   (ReadDataM),
    .MemStall    (MemStall),
    .bus_err     (bus_err),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ctrl    (mem_ctrl),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata)
  );

  // Clock and initial input values.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          waits;
    logic [31:0] data;
  } mem_rsp_t;

  mem_rsp_t    mem_q[$];       // scripted memory responses, in request order
  logic [67:0] exp_req_q[$];   // {we, addr, wdata, ctrl}
  logic [63:0] exp_out_q[$];   // {InstrF, ReadDataM} in DONE

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_instr = 32'h0000_0013;
  logic [31:0] exp_rd    = 32'h0;
  logic        exp_berr  = 1'b0;

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory model: negedge+1. Answers scripted requests after their wait
  // count; raises a spurious mem_ready when idle; drops everything on reset.
  always @(negedge clk) begin
    #1;
    if (reset) begin
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      mem_q.delete();
    end else if (!mem_req) begin
      mem_ready = 1'b1;
      mem_rdata = 32'hBAD0_BAD0;
    end else if (mem_q.size() == 0) begin
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
    end else if (mem_q[0].waits > 0) begin
      mem_q[0].waits = mem_q[0].waits - 1;
      mem_ready = 1'b0;
      mem_rdata = 32'h5A5A_5A5A;
    end else begin
      mem_ready = 1'b1;
      mem_rdata = mem_q[0].data;
      void'(mem_q.pop_front());
    end
  end

  // Monitor: negedge+2. Checks each completing request, request stability
  // across wait cycles, and the captured data in every DONE cycle.
  logic        prev_wait = 1'b0;
  logic [67:0] prev_fields;
  always @(negedge clk) begin
    logic [67:0] e;
    logic [67:0] cur;
    #2;
    cur = {mem_we, mem_addr, mem_wdata, mem_ctrl};
    if (reset) begin
      prev_wait = 1'b0;
    end else begin
      if (mem_req && prev_wait) check("req_stable", cur, prev_fields);
      if (mem_req && mem_ready) begin
        if (exp_req_q.size() == 0) begin
          check("req_unexpected", 68'd1, 68'd0);
        end else begin
          e = exp_req_q.pop_front();
          if (e[67]) check("req_fields", cur, e);
          else       check("req_fields", {mem_we, mem_addr, mem_ctrl}, {e[67:35], e[2:0]});
        end
      end
      prev_wait   = mem_req && !mem_ready;
      prev_fields = cur;
      if (!MemStall) begin
        if (exp_out_q.size() == 0) check("out_unexpected", 68'd1, 68'd0);
        else check("done_data", {4'd0, InstrF, ReadDataM}, {4'd0, exp_out_q.pop_front()});
      end
    end
  end

  // One pipeline step. Called at a negedge with the DUT in ARB; returns at the
  // negedge of the next ARB. berr_from: cycle of the step from which bus_err
  // must read 1 (0 = no change expected).
  task automatic do_step(input string name, input logic req, input logic we,
                         input logic [31:0] alu, input logic [31:0] wd,
                         input logic [2:0] ctl, input logic [31:0] pc,
                         input logic [31:0] d_rdata, input int d_wait,
                         input logic [31:0] f_rdata, input int f_wait,
                         input int exp_len, input int berr_from);
    logic [31:0] old_instr;
    logic [31:0] old_rd;
    logic        berr_exp;
    int          len;
    bit          done;
    old_instr = exp_instr;
    old_rd    = exp_rd;
    if (req) begin
      mem_q.push_back('{waits: d_wait, data: d_rdata});
      exp_req_q.push_back({we, alu, wd, ctl});
      if (!we) exp_rd = d_rdata;
    end
    mem_q.push_back('{waits: f_wait, data: f_rdata});
    exp_req_q.push_back({1'b0, pc, 32'h0, 3'b010});
    exp_instr = f_rdata;
    exp_out_q.push_back({exp_instr, exp_rd});
    MemReqM = req; MemWriteM = we; ALUResultM = alu; WriteDataM = wd;
    MemControlM = ctl; PCF = pc;
    len  = 0;
    done = 0;
    while (!done && len < 300) begin
      #3;
      len++;
      berr_exp = exp_berr || (berr_from > 0 && len >= berr_from);
      check({name, "_bus_err"}, {67'd0, bus_err}, {67'd0, berr_exp});
      if (!MemStall) begin
        done = 1;
      end else begin
        check({name, "_instr_hold"}, {36'd0, InstrF}, {36'd0, old_instr});
        if (!(req && !we)) check({name, "_rdata_hold"}, {36'd0, ReadDataM}, {36'd0, old_rd});
      end
      @(negedge clk);
    end
    if (berr_from > 0) exp_berr = 1'b1;
    check({name, "_step_len"}, 68'(len), 68'(exp_len));
  endtask

  // Stimulus.
  initial begin
    reset = 1'b1; mem_ready = 1'b0; mem_rdata = 32'h0;
    PCF = 32'h44; MemReqM = 1'b1; MemWriteM = 1'b1; ALUResultM = 32'h300;
    WriteDataM = 32'hFFFF_FFFF; MemControlM = 3'b111;
    repeat (2) @(negedge clk);
    #3;
    check("rst_mem_req",   {67'd0, mem_req},  68'd0);
    check("rst_mem_bus",   {mem_we, mem_addr, mem_wdata, mem_ctrl}, 68'd0);
    check("rst_stall",     {67'd0, MemStall}, 68'd1);
    check("rst_instr",     {36'd0, InstrF},   68'h13);
    check("rst_rdata",     {36'd0, ReadDataM}, 68'd0);
    check("rst_bus_err",   {67'd0, bus_err},  68'd0);
    @(negedge clk);
    reset = 1'b0;

    //        name      req   we    alu        wdata         ctl     pc       d_rdata       dw  f_rdata       fw len berr
    do_step("fetch0",  1'b0, 1'b0, 32'h0,    32'h0,        3'b000, 32'h0,  32'h0,        0, 32'h0050_0093, 0, 2,  0);
    do_step("load",    1'b1, 1'b0, 32'h100,  32'h0,        3'b010, 32'h4,  32'hDEAD_BEEF, 0, 32'h0000_0013, 0, 3,  0);
    do_step("store",   1'b1, 1'b1, 32'h200,  32'h1234_5678, 3'b010, 32'h8,  32'h0,        0, 32'h00A0_0113, 0, 3,  0);
    do_step("fwait",   1'b0, 1'b0, 32'h0,    32'h0,        3'b000, 32'hC,  32'h0,        0, 32'h0020_81B3, 3, 5,  0);
    do_step("ldwait",  1'b1, 1'b0, 32'h303,  32'h0,        3'b100, 32'h10, 32'h0000_00AB, 2, 32'h4020_8233, 1, 6,  0);
    do_step("wdog",    1'b0, 1'b0, 32'h0,    32'h0,        3'b000, 32'h14, 32'h0,        0, 32'h0000_0073, 10, 12, 6);
    do_step("sticky",  1'b0, 1'b0, 32'h0,    32'h0,        3'b000, 32'h18, 32'h0,        0, 32'h0010_0093, 0, 2,  0);

    // Load that the memory never answers, abandoned by reset.
    MemReqM = 1'b1; MemWriteM = 1'b0; ALUResultM = 32'h400; MemControlM = 3'b010;
    PCF = 32'h1C;
    mem_q.push_back('{waits: 50, data: 32'h1111_1111});
    repeat (3) @(negedge clk);
    reset = 1'b1;
    exp_instr = 32'h0000_0013;
    exp_rd    = 32'h0;
    exp_berr  = 1'b0;
    @(negedge clk);
    #3;
    check("midrst_mem_req", {67'd0, mem_req},   68'd0);
    check("midrst_stall",   {67'd0, MemStall},  68'd1);
    check("midrst_instr",   {36'd0, InstrF},    68'h13);
    check("midrst_bus_err", {67'd0, bus_err},   68'd0);
    @(negedge clk);
    reset = 1'b0;
    do_step("postrst", 1'b0, 1'b0, 32'h0,    32'h0,        3'b000, 32'h80, 32'h0,        0, 32'h0000_0113, 0, 2,  0);

    check("req_q_drained", 68'(exp_req_q.size()), 68'd0);
    check("out_q_drained", 68'(exp_out_q.size()), 68'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "timeout");
  end

endmodule
